hidden_act_layer: RTL and testbench
===================================

Name: hidden_act_layer

Overview:
- Parametrised hidden-layer activation stage for the float32 network.
- Accepts a vector of N_CH pre-activation sums and applies the selected activation (sigmoid, ReLU or identity) one channel per cycle through a single shared activation unit.
- Returns the activated vector over a valid/ready handshake.
- Holds the last completed vector in a back-pass store that the backpropagation logic reads by channel address.

Parameters:
- N_CH, 4, number of neurons (channels) per vector; legal range 1..64.
- FP_W, 32, float width; IEEE-754 single only, fixed at 32.
- AW, max(1,$clog2(N_CH)), channel address width (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in_sum  in  N_CH*32  pre-activation sums; channel i = bits [32*i+31:32*i]
- act_mode  in  2  0 = sigmoid, 1 = ReLU, 2 = identity, 3 = identity (reserved)
- out_valid  out  1  activated vector valid
- out_ready  in  1  consumer accepts the vector
- out_data  out  N_CH*32  activated vector, same channel packing as in_sum
- busy  out  1  high in every state except IDLE
- bk_rd_en  in  1  back-pass read strobe
- bk_addr  in  AW  back-pass channel index
- bk_data  out  32  back-pass read data
- bk_valid  out  1  bk_data valid; registered copy of bk_rd_en

Behaviour:
- Reset values:
  - state = IDLE, channel counter = 0.
  - in_ready = 1, out_valid = 0, busy = 0.
  - out_data, bk_data, bk_valid, internal sum buffer and back-pass store all 0.
- Reset takes effect immediately even mid-run. A partially processed vector is discarded; the store stays 0 until the next completed vector.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: in_ready = 1. On in_valid & in_ready, latch in_sum and act_mode into internal registers, clear the counter, go to RUN.
  - RUN: each cycle, register sum_buf[cnt] into x_q, record ch_q = cnt, increment cnt. After issuing channel N_CH-1, go to DRAIN.
  - Every edge after RUN's first edge writes act(x_q) into result[ch_q]. This is a one-cycle pipeline from issue to write.
  - DRAIN: writes the final channel, copies the full result vector into the back-pass store on the same edge, goes to DONE.
  - DONE: out_valid = 1 and out_data = result. out_data stays stable while out_ready = 0. On out_ready, go to IDLE.
  - in_ready rises the cycle after the handshake; there is no same-cycle re-accept.
- Latency: with the accept edge counted as edge 0, out_valid is visible after edge N_CH+1.
- Throughput: one vector per N_CH+3 cycles when out_ready is held high.
- Mode and input changes after the accept edge are ignored until the next accept.
- Activation rules:
  - Sigmoid: result of the team's combinational sigmoid on x_q.
  - ReLU: if sign bit = 1, output 0x00000000; otherwise pass x_q unchanged. This applies to -0.0, negative NaN and -inf alike (all give +0). Positive NaN and +inf pass through.
  - Identity: pass x_q unchanged.
- Back-pass read:
  - bk_data <= store[bk_addr] and bk_valid <= bk_rd_en, both registered, one-cycle latency.
  - When bk_rd_en = 0, bk_data holds its last value.
  - If a read and the store commit happen on the same edge, the read returns the old contents.
  - bk_addr >= N_CH returns 0x00000000 with bk_valid asserted.
- N_CH = 1: RUN lasts one cycle; the counter stays 0.

Decomposition:
- Shared package nn_pkg:
  - ACT_SIGMOID/ACT_RELU/ACT_IDENT/ACT_RSVD 2-bit constants.
  - FP_ZERO = 32'h00000000, FP_HALF = 32'h3F000000, FP_ONE = 32'h3F800000.
  - Hidden-layer FSM state enum.
- One sub-module, act_unit: a combinational mux of the existing sigmoid instance, the ReLU sign-bit gate and identity, selected by the latched mode.

Test Plan:
- Sigmoid, N_CH=4, in_sum = 4×0x00000000, out_ready=1 → out_valid after edge 5; out_data = 4×0x3F000000; then in_ready=1.
- ReLU, in_sum = {0xC0000000, 0x40400000, 0x80000000, 0x7FC00000} → {0x00000000, 0x40400000, 0x00000000, 0x7FC00000}.
- Identity (mode 3) with out_ready held 0 for 10 cycles → out_valid stays high, out_data equals in_sum and is stable, in_ready=0, busy=1. Release → IDLE next cycle.
- Back-pass read of addr 2 during a second vector's RUN → returns the first vector's channel 2. Read on the DRAIN edge → old value; read on the next cycle → new value; bk_valid lags bk_rd_en by 1 cycle.
- Assert rst_n=0 during RUN (channel 2 issued) → out_valid=0, in_ready=1, store reads 0x00000000. Next vector completes with the full N_CH+1 latency.
- Change act_mode and in_sum the cycle after accept → output reflects the originally latched values.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared constants and types for the float32 network layers.
// Activation mode encodings, common float constants and the hidden-layer FSM states.
package nn_pkg;

    localparam logic [1:0] ACT_SIGMOID = 2'd0;
    localparam logic [1:0] ACT_RELU    = 2'd1;
    localparam logic [1:0] ACT_IDENT   = 2'd2;
    localparam logic [1:0] ACT_RSVD    = 2'd3;

    localparam logic [31:0] FP_ZERO = 32'h00000000;
    localparam logic [31:0] FP_HALF = 32'h3F000000;
    localparam logic [31:0] FP_ONE  = 32'h3F800000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } hid_state_e;

endpackage

// File: rtl/act_unit.sv
// Combinational float32 activation: piecewise-linear sigmoid, ReLU sign gate or identity.
// The sigmoid works on |x| in Q3.16 fixed point and mirrors around 0.5 for negative inputs.
module act_unit
    import nn_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic [31:0] x,
    output logic [31:0] y
);

    logic [7:0]  x_exp;
    logic [23:0] mant;
    logic [18:0] fix;
    logic [16:0] mag;
    logic [16:0] sig_q;
    logic [4:0]  lead;
    logic [22:0] frac;
    logic [31:0] sig_y;

    assign x_exp = x[30:23];
    assign mant  = {1'b1, x[22:0]};

    always_comb begin
        fix = '0;
        if (x_exp >= 8'd130) begin
            fix = 19'h7FFFF;
        end else if (x_exp >= 8'd110) begin
            fix = 19'(mant >> (8'd134 - x_exp));
        end

        // Segment breakpoints at 1.0, 2.375 and 5.0 in Q3.16.
        if (fix >= 19'd327680) begin
            mag = 17'h10000;
        end else if (fix >= 19'd155648) begin
            mag = 17'(fix >> 5) + 17'd55296;
        end else if (fix >= 19'd65536) begin
            mag = 17'(fix >> 3) + 17'd40960;
        end else begin
            mag = 17'(fix >> 2) + 17'd32768;
        end

        sig_q = x[31] ? (17'h10000 - mag) : mag;

        lead = '0;
        for (int i = 0; i < 17; i++) begin
            if (sig_q[i]) lead = 5'(i);
        end

        frac  = {6'b0, sig_q} << (5'd23 - lead);
        sig_y = FP_ZERO;
        if (sig_q != '0) begin
            sig_y = {1'b0, 8'(8'd111 + {3'b0, lead}), frac};
        end

        case (mode)
            ACT_SIGMOID: y = sig_y;
            ACT_RELU:    y = x[31] ? FP_ZERO : x;
            default:     y = x;
        endcase
    end

endmodule

// File: rtl/hidden_act_layer.sv
// Hidden-layer activation stage: activates one channel per cycle through a shared act_unit
// and keeps the last completed vector in a back-pass store for the backpropagation logic.
module hidden_act_layer
    import nn_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int FP_W = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [N_CH*FP_W-1:0]              in_sum,
    input  logic [1:0]                        act_mode,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [N_CH*FP_W-1:0]              out_data,
    output logic                              busy,
    input  logic                              bk_rd_en,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] bk_addr,
    output logic [FP_W-1:0]                   bk_data,
    output logic                              bk_valid
);

    localparam int AW = (N_CH > 1) ? $clog2(N_CH) : 1;

    hid_state_e    state, state_nxt;
    logic [AW-1:0] cnt;
    logic [AW-1:0] ch_q;
    logic [1:0]    mode_q;
    logic [FP_W-1:0] x_q;
    logic          x_vld;
    logic [FP_W-1:0] act_y;
    logic          last_ch;
    logic [FP_W-1:0] sum_buf [N_CH];
    logic [FP_W-1:0] result  [N_CH];
    logic [FP_W-1:0] store   [N_CH];

    assign last_ch = (cnt == AW'(N_CH - 1));

    act_unit u_act (
        .mode (mode_q),
        .x    (x_q),
        .y    (act_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = RUN;
            end
            RUN:   if (last_ch) state_nxt = DRAIN;
            DRAIN: state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue stage registers one channel per RUN cycle; the write lands one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            ch_q   <= '0;
            mode_q <= ACT_SIGMOID;
            x_q    <= '0;
            x_vld  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                sum_buf[i] <= '0;
                result[i]  <= '0;
                store[i]   <= '0;
            end
        end else begin
            x_vld <= (state == RUN);
            if (state == IDLE && in_valid) begin
                for (int i = 0; i < N_CH; i++) begin
                    sum_buf[i] <= in_sum[FP_W*i +: FP_W];
                end
                mode_q <= act_mode;
                cnt    <= '0;
            end
            if (state == RUN) begin
                x_q  <= sum_buf[cnt];
                ch_q <= cnt;
                cnt  <= last_ch ? '0 : cnt + AW'(1);
            end
            if (x_vld) begin
                result[ch_q] <= act_y;
            end
            if (state == DRAIN) begin
                for (int i = 0; i < N_CH; i++) begin
                    store[i] <= (x_vld && ch_q == AW'(i)) ? act_y : result[i];
                end
            end
        end
    end

    // Back-pass reads see the store as it was before any same-edge commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bk_data  <= '0;
            bk_valid <= 1'b0;
        end else begin
            bk_valid <= bk_rd_en;
            if (bk_rd_en) begin
                bk_data <= ({1'b0, bk_addr} < (AW+1)'(N_CH)) ? store[bk_addr] : FP_ZERO;
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            out_data[FP_W*i +: FP_W] = result[i];
        end
    end

endmodule

// File: tb/tb_hidden_act_layer.sv
// Scoreboard bench for hidden_act_layer: a driver pushes expected vectors, a monitor pops and
// compares them whenever the DUT presents a vector; sigmoid is judged against the exact function.
module tb_hidden_act_layer;
    import nn_pkg::*;

    localparam int N_CH = 4;
    localparam int AW   = 2;
    localparam int W    = N_CH * 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_sum = '0;
    logic [1:0]    act_mode = 2'd0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          busy;
    logic          bk_rd_en = 1'b0;
    logic [AW-1:0] bk_addr = '0;
    logic [31:0]   bk_data;
    logic          bk_valid;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] sums;
        logic [W-1:0] expv;
        bit           approx;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] bk_model [N_CH];
    bit          bk_exact = 1'b1;

    hidden_act_layer #(.N_CH(N_CH), .FP_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .act_mode  (act_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .bk_rd_en  (bk_rd_en),
        .bk_addr   (bk_addr),
        .bk_data   (bk_data),
        .bk_valid  (bk_valid)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        m = m * (2.0 ** real'(e - 127));
        return b[31] ? -m : m;
    endfunction

    function automatic real sigmoid_ref(input real x);
        return 1.0 / (1.0 + $exp(-x));
    endfunction

    function automatic logic [31:0] ref_act(input logic [1:0] mode, input logic [31:0] x);
        if (mode == ACT_RELU && x[31]) return FP_ZERO;
        return x;
    endfunction

    function automatic logic [W-1:0] random_vec(input bit sig_range);
        logic [W-1:0] v;
        logic [31:0]  w;
        for (int i = 0; i < N_CH; i++) begin
            if (sig_range) begin
                w = {1'($urandom_range(0, 1)), 8'($urandom_range(110, 130)), 23'($urandom)};
            end else if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 5))
                    0:       w = 32'h00000000;
                    1:       w = 32'h80000000;
                    2:       w = 32'h7F800000;
                    3:       w = 32'hFF800000;
                    4:       w = 32'h7FC00000;
                    default: w = 32'hFFC00000;
                endcase
            end else begin
                w = 32'($urandom);
            end
            v[32*i +: 32] = w;
        end
        return v;
    endfunction

    task automatic check_output(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic check_sigmoid(input exp_t e);
        bit          ok;
        logic [31:0] y;
        real         err;
        ok = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            y   = out_data[32*i +: 32];
            err = f2r(y) - sigmoid_ref(f2r(e.sums[32*i +: 32]));
            if (err < 0.0) err = -err;
            if (y[31] || err > 0.021) ok = 1'b0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("[TB] FAIL sigmoid: got %h for inputs %h", out_data, e.sums);
        end
    endtask

    // Monitor: pops the scoreboard on each new presentation, checks stability while stalled.
    initial begin : monitor
        logic [W-1:0] held;
        bit           presenting;
        exp_t         e;
        presenting = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                presenting = 1'b0;
            end else if (out_valid) begin
                if (!presenting) begin
                    presenting = 1'b1;
                    held       = out_data;
                    if (sb_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL unexpected_output: got %h expected no output", out_data);
                    end else begin
                        e = sb_q.pop_front();
                        if (e.approx) check_sigmoid(e);
                        else          check_output("out_data", out_data, e.expv);
                    end
                end else begin
                    check_output("stall_hold", out_data, held);
                    check_output("stall_flags", W'({in_ready, busy}), W'(2'b01));
                end
                if (out_ready) presenting = 1'b0;
            end
        end
    end

    task automatic apply_stimulus(input logic [1:0] mode, input logic [W-1:0] sums,
                                  input int hold, input bit probe);
        exp_t        e;
        int          k;
        logic [31:0] old2;
        bit          all_zero;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            check_output("in_ready_timeout", W'(in_ready), W'(1));
            return;
        end
        all_zero = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (sums[32*i +: 31] != '0) all_zero = 1'b0;
        end
        e.mode   = mode;
        e.sums   = sums;
        e.approx = (mode == ACT_SIGMOID) && !all_zero;
        for (int i = 0; i < N_CH; i++) begin
            e.expv[32*i +: 32] = (mode == ACT_SIGMOID) ? FP_HALF : ref_act(mode, sums[32*i +: 32]);
        end
        old2      = bk_model[2];
        act_mode  = mode;
        in_sum    = sums;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        act_mode = 2'($urandom);
        in_sum   = random_vec(1'b0);
        if (probe) begin
            bk_rd_en = 1'b1;
            bk_addr  = 2'd2;
        end
        for (k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (probe) begin
                if (k == 1) begin
                    check_output("bk_run_read", W'({bk_valid, bk_data}), W'({1'b1, old2}));
                    bk_rd_en = 1'b0;
                end else if (k == 2) begin
                    check_output("bk_hold", W'({bk_valid, bk_data}), W'({1'b0, old2}));
                end
                if (k == N_CH) bk_rd_en = 1'b1;
                else if (k == N_CH + 1)
                    check_output("bk_drain_old", W'({bk_valid, bk_data}), W'({1'b1, old2}));
            end
            if (out_valid) break;
        end
        check_output("latency", W'(k), W'(N_CH + 1));
        bk_exact = !e.approx;
        for (int i = 0; i < N_CH; i++) bk_model[i] = e.expv[32*i +: 32];
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check_output("post_handshake", W'({in_ready, out_valid, busy}), W'(3'b100));
        if (probe) begin
            check_output("bk_new", W'({bk_valid, bk_data}), W'({1'b1, bk_model[2]}));
            bk_rd_en = 1'b0;
        end
    endtask

    task automatic read_bk(input logic [AW-1:0] addr);
        @(negedge clk);
        bk_rd_en = 1'b1;
        bk_addr  = addr;
        @(posedge clk);
        #1;
        check_output("bk_read", W'({bk_valid, bk_data}), W'({1'b1, bk_model[addr]}));
        bk_rd_en = 1'b0;
    endtask

    task automatic reset_mid_run(input logic [W-1:0] sums);
        int k;
        @(negedge clk);
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        act_mode = ACT_IDENT;
        in_sum   = sums;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("mid_reset_flags", W'({out_valid, in_ready, busy}), W'(3'b010));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N_CH; i++) bk_model[i] = FP_ZERO;
        bk_exact = 1'b1;
        for (int i = 0; i < N_CH; i++) read_bk(AW'(i));
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        logic [1:0] m;
        for (int i = 0; i < N_CH; i++) bk_model[i] = FP_ZERO;
        #2;
        rst_n = 1'b0;
        #2;
        check_output("reset_flags", W'({in_ready, out_valid, busy, bk_valid}), W'(4'b1000));
        check_output("reset_data", out_data, '0);
        check_output("reset_bk", W'(bk_data), '0);
        @(negedge clk);
        rst_n = 1'b1;

        apply_stimulus(ACT_SIGMOID, '0, 0, 1'b0);
        apply_stimulus(ACT_RELU, {32'hC0000000, 32'h40400000, 32'h80000000, 32'h7FC00000}, 0, 1'b0);
        apply_stimulus(ACT_RSVD, random_vec(1'b0), 10, 1'b0);
        read_bk(2'd2);
        apply_stimulus(ACT_RELU, random_vec(1'b0), 0, 1'b1);
        reset_mid_run(random_vec(1'b0));
        apply_stimulus(ACT_IDENT, random_vec(1'b0), 0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            m = 2'($urandom_range(0, 3));
            apply_stimulus(m, random_vec(m == ACT_SIGMOID), $urandom_range(0, 3), 1'b0);
            if (bk_exact) read_bk(AW'($urandom_range(0, N_CH - 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        check_output("sb_drained", W'(sb_q.size()), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
